// File: rtl/intrapred_pkg.sv
// rtl/intrapred_pkg.sv - shared types and constants for the intra-prediction fetch path
package intrapred_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CORNER = 3'd1,
        ST_TOP    = 3'd2,
        ST_LEFT   = 3'd3,
        ST_BLOCK  = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_VALID  = 3'd6
    } fetch_state_t;

    // Tag carried alongside each outstanding read: which capture bank it lands in.
    typedef enum logic [1:0] {
        PH_CORNER = 2'd0,
        PH_TOP    = 2'd1,
        PH_LEFT   = 2'd2,
        PH_BLOCK  = 2'd3
    } fetch_phase_t;

    // Value substituted for neighbours outside the frame.
    localparam logic [7:0] PIX_FILL = 8'd128;

endpackage

// File: rtl/mb_fetch_tagpipe.sv
// rtl/mb_fetch_tagpipe.sv - read-tag delay line matching the frame-buffer latency
//  clk, reset      : clock, synchronous active-high clear (drops in-flight tags)
//  in_valid/phase/idx   : tag of the read issued this cycle
//  out_valid/phase/idx  : tag whose read data is on mem_rdata this cycle
module mb_fetch_tagpipe
    import intrapred_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  fetch_phase_t     in_phase,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output fetch_phase_t     out_phase,
    output logic [IDX_W-1:0] out_idx
);

    typedef struct packed {
        logic             valid;
        fetch_phase_t     phase;
        logic [IDX_W-1:0] idx;
    } tag_t;

    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0].valid = in_valid;
        pipe_d[0].phase = in_phase;
        pipe_d[0].idx   = in_idx;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign out_valid = pipe_q[DEPTH-1].valid;
    assign out_phase = pipe_q[DEPTH-1].phase;
    assign out_idx   = pipe_q[DEPTH-1].idx;

endmodule

// File: rtl/mb_fetcher.sv
// rtl/mb_fetcher.sv - fetches one block plus top/left neighbours from the frame buffer
//  clk, reset                : clock, synchronous active-high reset
//  start, mbnumber           : fetch request (raster block index), sampled in IDLE
//  mem_rd_en/addr/rdata      : frame-buffer read port, fixed MEM_LATENCY
//  mb_pixels/top_pixels/left_pixels, top_avail/left_avail : fetched block and neighbours
//  mb_valid, mb_ready        : output handshake
//  busy, err                 : not-idle flag, 1-cycle out-of-range start pulse
module mb_fetcher
    import intrapred_pkg::*;
#(
    parameter int MB_NUMBER_BITS = 12,
    parameter int MB_SIZE        = 4,
    parameter int TOP_EXT        = 1,
    parameter int FRAME_W        = 176,
    parameter int FRAME_H        = 144,
    parameter int ADDR_BITS      = 16,
    parameter int MEM_LATENCY    = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [MB_NUMBER_BITS:0]                mbnumber,
    output logic                                   mem_rd_en,
    output logic [ADDR_BITS-1:0]                   mem_addr,
    input  logic [7:0]                             mem_rdata,
    output logic [8*MB_SIZE*MB_SIZE-1:0]           mb_pixels,
    output logic [8*MB_SIZE*(1+TOP_EXT)-1:0]       top_pixels,
    output logic [8*(MB_SIZE+1)-1:0]               left_pixels,
    output logic                                   top_avail,
    output logic                                   left_avail,
    output logic                                   mb_valid,
    input  logic                                   mb_ready,
    output logic                                   busy,
    output logic                                   err
);

    localparam int N     = MB_SIZE;
    localparam int TW    = N * (1 + TOP_EXT);
    localparam int MBW   = MB_NUMBER_BITS + 1;
    localparam int IDX_W = $clog2(N * N);
    localparam int DW    = $clog2(MEM_LATENCY) + 1;
    localparam logic [MBW-1:0] BW_C    = MBW'(FRAME_W / N);
    localparam logic [MBW-1:0] TOTAL_C = MBW'((FRAME_W / N) * (FRAME_H / N));

    fetch_state_t             state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DW-1:0]            drain_q, drain_d;
    logic [ADDR_BITS-1:0]     x0_q, x0_d, y0_q, y0_d;
    logic                     top_avail_q, top_avail_d;
    logic                     left_avail_q, left_avail_d;
    logic                     tr_ok_q, tr_ok_d;
    logic                     err_q, err_d;
    logic [8*N*N-1:0]         mb_q, mb_d;
    logic [8*TW-1:0]          top_q, top_d;
    logic [8*(N+1)-1:0]       left_q, left_d;

    logic [MBW-1:0]           mb_x, mb_y;
    logic                     start_ok;
    logic [IDX_W-1:0]         top_last;

    logic                     rd_en;
    fetch_phase_t             rd_phase;
    logic [ADDR_BITS-1:0]     row, col;

    logic                     tag_valid;
    fetch_phase_t             tag_phase;
    logic [IDX_W-1:0]         tag_idx;

    assign mb_x     = mbnumber % BW_C;
    assign mb_y     = mbnumber / BW_C;
    assign start_ok = (state_q == ST_IDLE) && start && (mbnumber < TOTAL_C);
    // Only issued top reads are counted; the top-right half is skipped at the right frame edge.
    assign top_last = tr_ok_q ? IDX_W'(2*N - 1) : IDX_W'(N - 1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        top_avail_d  = top_avail_q;
        left_avail_d = left_avail_q;
        tr_ok_d      = tr_ok_q;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !start_ok) begin
                    err_d = 1'b1;
                end else if (start_ok) begin
                    x0_d         = ADDR_BITS'(mb_x) * ADDR_BITS'(N);
                    y0_d         = ADDR_BITS'(mb_y) * ADDR_BITS'(N);
                    top_avail_d  = (mb_y != '0);
                    left_avail_d = (mb_x != '0);
                    tr_ok_d      = (TOP_EXT != 0) && (mb_x + MBW'(2) <= BW_C);
                    idx_d        = '0;
                    if (mb_y != '0 && mb_x != '0) state_d = ST_CORNER;
                    else if (mb_y != '0)          state_d = ST_TOP;
                    else if (mb_x != '0)          state_d = ST_LEFT;
                    else                          state_d = ST_BLOCK;
                end
            end
            ST_CORNER: begin
                idx_d   = '0;
                state_d = ST_TOP;
            end
            ST_TOP: begin
                if (idx_q == top_last) begin
                    idx_d   = '0;
                    state_d = left_avail_q ? ST_LEFT : ST_BLOCK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_LEFT: begin
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d   = '0;
                    state_d = ST_BLOCK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_BLOCK: begin
                if (idx_q == IDX_W'(N*N - 1)) begin
                    idx_d   = '0;
                    drain_d = DW'(MEM_LATENCY - 1);
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_VALID;
                else               drain_d = drain_q - 1'b1;
            end
            ST_VALID: begin
                if (mb_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en    = 1'b0;
        rd_phase = PH_BLOCK;
        row      = y0_q;
        col      = x0_q;
        case (state_q)
            ST_CORNER: begin
                rd_en    = 1'b1;
                rd_phase = PH_CORNER;
                row      = y0_q - ADDR_BITS'(1);
                col      = x0_q - ADDR_BITS'(1);
            end
            ST_TOP: begin
                rd_en    = 1'b1;
                rd_phase = PH_TOP;
                row      = y0_q - ADDR_BITS'(1);
                col      = x0_q + ADDR_BITS'(idx_q);
            end
            ST_LEFT: begin
                rd_en    = 1'b1;
                rd_phase = PH_LEFT;
                row      = y0_q + ADDR_BITS'(idx_q);
                col      = x0_q - ADDR_BITS'(1);
            end
            ST_BLOCK: begin
                rd_en    = 1'b1;
                rd_phase = PH_BLOCK;
                row      = y0_q + ADDR_BITS'(idx_q / IDX_W'(N));
                col      = x0_q + ADDR_BITS'(idx_q % IDX_W'(N));
            end
            default: ;
        endcase
    end

    mb_fetch_tagpipe #(
        .DEPTH (MEM_LATENCY),
        .IDX_W (IDX_W)
    ) u_tagpipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_en),
        .in_phase  (rd_phase),
        .in_idx    (idx_q),
        .out_valid (tag_valid),
        .out_phase (tag_phase),
        .out_idx   (tag_idx)
    );

    // Neighbours are pre-filled at start; reads that are actually issued overwrite the fill.
    always_comb begin
        mb_d   = mb_q;
        top_d  = top_q;
        left_d = left_q;
        if (start_ok) begin
            top_d  = {TW{PIX_FILL}};
            left_d = {(N+1){PIX_FILL}};
        end
        if (tag_valid) begin
            case (tag_phase)
                PH_CORNER: left_d[7:0] = mem_rdata;
                PH_TOP: begin
                    top_d[8*int'(tag_idx) +: 8] = mem_rdata;
                    // Top-right beyond the frame edge replicates the last in-frame top pixel.
                    if (TOP_EXT != 0 && !tr_ok_q && tag_idx == IDX_W'(N - 1)) begin
                        for (int j = N; j < TW; j++) begin
                            top_d[8*j +: 8] = mem_rdata;
                        end
                    end
                end
                PH_LEFT:  left_d[8*(int'(tag_idx) + 1) +: 8] = mem_rdata;
                PH_BLOCK: mb_d[8*int'(tag_idx) +: 8] = mem_rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            drain_q      <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            top_avail_q  <= 1'b0;
            left_avail_q <= 1'b0;
            tr_ok_q      <= 1'b0;
            err_q        <= 1'b0;
            mb_q         <= '0;
            top_q        <= '0;
            left_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            top_avail_q  <= top_avail_d;
            left_avail_q <= left_avail_d;
            tr_ok_q      <= tr_ok_d;
            err_q        <= err_d;
            mb_q         <= mb_d;
            top_q        <= top_d;
            left_q       <= left_d;
        end
    end

    assign mem_rd_en   = rd_en;
    assign mem_addr    = rd_en ? (row * ADDR_BITS'(FRAME_W) + col) : '0;
    assign mb_pixels   = mb_q;
    assign top_pixels  = top_q;
    assign left_pixels = left_q;
    assign top_avail   = top_avail_q;
    assign left_avail  = left_avail_q;
    assign mb_valid    = (state_q == ST_VALID);
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_mb_fetcher.sv
// tb/tb_mb_fetcher.sv - self-checking bench for mb_fetcher against a frame-level reference model
module tb_mb_fetcher;

    localparam int N     = 4;
    localparam int EXT   = 1;
    localparam int W     = 176;
    localparam int H     = 144;
    localparam int AB    = 16;
    localparam int L     = 2;
    localparam int MBB   = 12;
    localparam int TW    = N * (1 + EXT);
    localparam int BW    = W / N;
    localparam int TOTAL = BW * (H / N);
    localparam int CW    = 8 * N * N;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [MBB:0]         mbnumber = '0;
    logic                 mem_rd_en;
    logic [AB-1:0]        mem_addr;
    logic [7:0]           mem_rdata;
    logic [8*N*N-1:0]     mb_pixels;
    logic [8*TW-1:0]      top_pixels;
    logic [8*(N+1)-1:0]   left_pixels;
    logic                 top_avail, left_avail, mb_valid, busy, err;
    logic                 mb_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mb_fetcher #(
        .MB_NUMBER_BITS (MBB),
        .MB_SIZE        (N),
        .TOP_EXT        (EXT),
        .FRAME_W        (W),
        .FRAME_H        (H),
        .ADDR_BITS      (AB),
        .MEM_LATENCY    (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mbnumber    (mbnumber),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mb_pixels   (mb_pixels),
        .top_pixels  (top_pixels),
        .left_pixels (left_pixels),
        .top_avail   (top_avail),
        .left_avail  (left_avail),
        .mb_valid    (mb_valid),
        .mb_ready    (mb_ready),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Frame buffer: rdata = addr[7:0], presented L cycles after the read cycle, stable at posedge.
    logic [AB-1:0] mem_pipe [0:L];
    always @(negedge clk) begin
        mem_pipe[0] <= mem_addr;
        for (int i = 1; i <= L; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign mem_rdata = mem_pipe[L][7:0];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    int                 exp_reads[$];
    logic [8*N*N-1:0]   exp_mb;
    logic [8*TW-1:0]    exp_top;
    logic [8*(N+1)-1:0] exp_left;
    bit                 exp_ta, exp_la;

    logic [8*N*N-1:0]   obs_mb;
    logic [8*TW-1:0]    obs_top;
    logic [8*(N+1)-1:0] obs_left;
    int                 obs_nreads, obs_vcyc;

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'((y * W + x) & 255);
    endfunction

    task automatic build_model(input int mb);
        int bx, by, x0, y0;
        bit tr;
        bx = mb % BW;
        by = mb / BW;
        x0 = bx * N;
        y0 = by * N;
        exp_reads.delete();
        exp_ta = (by > 0);
        exp_la = (bx > 0);
        tr = (x0 + 2 * N <= W);
        if (exp_ta && exp_la) begin
            exp_left[7:0] = pix(x0 - 1, y0 - 1);
            exp_reads.push_back((y0 - 1) * W + x0 - 1);
        end else begin
            exp_left[7:0] = 8'd128;
        end
        for (int i = 0; i < TW; i++) begin
            if (!exp_ta) begin
                exp_top[8*i +: 8] = 8'd128;
            end else if (i < N || tr) begin
                exp_top[8*i +: 8] = pix(x0 + i, y0 - 1);
                exp_reads.push_back((y0 - 1) * W + x0 + i);
            end else begin
                exp_top[8*i +: 8] = pix(x0 + N - 1, y0 - 1);
            end
        end
        for (int r = 0; r < N; r++) begin
            if (exp_la) begin
                exp_left[8*(r+1) +: 8] = pix(x0 - 1, y0 + r);
                exp_reads.push_back((y0 + r) * W + x0 - 1);
            end else begin
                exp_left[8*(r+1) +: 8] = 8'd128;
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_mb[8*(r*N+c) +: 8] = pix(x0 + c, y0 + r);
                exp_reads.push_back((y0 + r) * W + x0 + c);
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after accept.
    task automatic do_fetch(input int mb, input int hold, input bit noise, input string tag);
        int c, nr, vcyc;
        bit bad_addr, bad_busy, bad_hold;
        build_model(mb);
        nr = 0; vcyc = 0; bad_addr = 0; bad_busy = 0; bad_hold = 0;
        mb_ready = 1'b0;
        start = 1'b1;
        mbnumber = (MBB+1)'(mb);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 500) begin
            if (!busy) bad_busy = 1;
            if (mem_rd_en) begin
                if (nr >= exp_reads.size() || exp_reads[nr] != int'(mem_addr)) bad_addr = 1;
                nr++;
            end
            if (mb_valid) begin
                vcyc = c;
                break;
            end
            if (noise) begin
                start = 1'(($urandom & 1));
                mbnumber = (MBB+1)'($urandom);
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        obs_mb = mb_pixels; obs_top = top_pixels; obs_left = left_pixels;
        obs_nreads = nr; obs_vcyc = vcyc;
        check({tag, ":nreads"}, CW'(nr), CW'(exp_reads.size()));
        check({tag, ":addr_seq_bad"}, CW'(bad_addr), CW'(0));
        check({tag, ":busy_drop"}, CW'(bad_busy), CW'(0));
        check({tag, ":valid_cycle"}, CW'(vcyc), CW'(exp_reads.size() + L + 1));
        check({tag, ":mb_pixels"}, CW'(mb_pixels), CW'(exp_mb));
        check({tag, ":top_pixels"}, CW'(top_pixels), CW'(exp_top));
        check({tag, ":left_pixels"}, CW'(left_pixels), CW'(exp_left));
        check({tag, ":top_avail"}, CW'(top_avail), CW'(exp_ta));
        check({tag, ":left_avail"}, CW'(left_avail), CW'(exp_la));
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                start = 1'b1;
                mbnumber = (MBB+1)'($urandom);
            end
            @(negedge clk);
            if (mem_rd_en || !mb_valid || err || mb_pixels !== exp_mb || top_pixels !== exp_top
                || left_pixels !== exp_left || top_avail !== exp_ta || left_avail !== exp_la)
                bad_hold = 1;
        end
        start = noise;
        mb_ready = 1'b1;
        @(negedge clk);
        mb_ready = 1'b0;
        start = 1'b0;
        check({tag, ":hold_stable_bad"}, CW'(bad_hold), CW'(0));
        check({tag, ":valid_after_accept"}, CW'(mb_valid), CW'(0));
        check({tag, ":busy_after_accept"}, CW'(busy), CW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int c;
        bit bad;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst:busy", CW'(busy), CW'(0));
        check("rst:mem_rd_en", CW'(mem_rd_en), CW'(0));
        check("rst:mb_valid", CW'(mb_valid), CW'(0));
        check("rst:err", CW'(err), CW'(0));
        check("rst:mb_pixels", CW'(mb_pixels), CW'(0));
        check("rst:top_pixels", CW'(top_pixels), CW'(0));
        check("rst:left_pixels", CW'(left_pixels), CW'(0));
        check("rst:avail", CW'({top_avail, left_avail}), CW'(0));
        reset = 1'b0;

        // Frame corner: nothing available
        do_fetch(0, 0, 0, "mb0");
        check("mb0:nreads_const", CW'(obs_nreads), CW'(16));
        check("mb0:valid_cyc_const", CW'(obs_vcyc), CW'(19));
        check("mb0:pix5_const", CW'(obs_mb[8*5 +: 8]), CW'(177));
        check("mb0:left_const", CW'(obs_left), CW'({5{8'd128}}));

        // Interior block, first available start right after accept
        do_fetch(45, 0, 0, "mb45");
        check("mb45:valid_cyc_const", CW'(obs_vcyc), CW'(32));
        check("mb45:corner_const", CW'(obs_left[7:0]), CW'(19));
        check("mb45:left1_const", CW'(obs_left[15:8]), CW'(195));
        check("mb45:mb0_const", CW'(obs_mb[7:0]), CW'(196));

        // Right frame edge: top-right replicated
        do_fetch(87, 0, 0, "mb87");
        check("mb87:nreads_const", CW'(obs_nreads), CW'(25));
        check("mb87:top7_const", CW'(obs_top[63:56]), CW'(191));
        check("mb87:top3_const", CW'(obs_top[31:24]), CW'(191));

        // Back-pressure with start pulsing during busy
        do_fetch(45, 10, 1, "hold");
        do_fetch(1583, 0, 0, "last");

        // Reset in the middle of a fetch
        start = 1'b1;
        mbnumber = (MBB+1)'(45);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 10) begin
            @(negedge clk);
            c++;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst:mem_rd_en", CW'(mem_rd_en), CW'(0));
        check("midrst:busy", CW'(busy), CW'(0));
        check("midrst:pixels", CW'(mb_pixels), CW'(0));
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mb_valid || mem_rd_en || busy) bad = 1;
        end
        check("midrst:quiet_bad", CW'(bad), CW'(0));
        do_fetch(0, 0, 0, "postrst");
        check("postrst:pix5_const", CW'(obs_mb[8*5 +: 8]), CW'(177));

        // Out-of-range start
        start = 1'b1;
        mbnumber = (MBB+1)'(TOTAL);
        @(negedge clk);
        start = 1'b0;
        check("err:pulse", CW'(err), CW'(1));
        check("err:busy", CW'(busy), CW'(0));
        check("err:rd_en", CW'(mem_rd_en), CW'(0));
        @(negedge clk);
        check("err:pulse_end", CW'(err), CW'(0));
        check("err:busy2", CW'(busy), CW'(0));
        check("err:rd_en2", CW'(mem_rd_en), CW'(0));

        // Randomized blocks, hold lengths and start noise
        for (int k = 0; k < 25; k++) begin
            do_fetch(int'($urandom_range(0, TOTAL - 1)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
